// File: rtl/complete_buffer.sv
// rtl/complete_buffer.sv - in-order completion FIFO between function units and the ROB
// Captures up to NUM_FU results per cycle and retires up to three per cycle to the ROB.
module complete_buffer #(
  parameter int ROB_IDX_W = 5,
  parameter int XLEN      = 32,
  parameter int NUM_FU    = 4,
  parameter int DEPTH     = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_FU-1:0]                   fu_valid,
  input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]    fu_rob_idx,
  input  logic [NUM_FU-1:0]                   fu_mispredict,
  input  logic [NUM_FU-1:0][XLEN-1:0]         fu_target_pc,
  output logic [NUM_FU-1:0]                   fu_ready,
  input  logic                                BPRecoverEN,
  output logic [2:0]                          complete_valid,
  output logic [2:0][ROB_IDX_W-1:0]           complete_entry,
  output logic [2:0]                          precise_state_valid,
  output logic [2:0][XLEN-1:0]                target_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROB_IDX_W-1:0] mem_idx [DEPTH];
  logic                 mem_mis [DEPTH];
  logic [XLEN-1:0]      mem_pc  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [1:0]                   deq_n;
  logic [CNT_W:0]               space;
  logic                         ready;
  logic                         live;
  logic [2:0]                   enq_n;
  logic [2:0]                   enq_take;
  logic [NUM_FU-1:0][PTR_W-1:0] wr_off;
  logic [PTR_W-1:0]             rd_ptr [3];

  // Readiness is derived from registered count alone, so no fu_valid -> fu_ready path exists.
  always_comb begin
    deq_n = (count >= CNT_W'(3)) ? 2'd3 : count[1:0];
    space = (CNT_W+1)'(DEPTH) - (CNT_W+1)'(count) + (CNT_W+1)'(deq_n);
    ready = (space >= (CNT_W+1)'(NUM_FU));
    fu_ready = {NUM_FU{ready}};
    live = reset & ~BPRecoverEN;
  end

  // Valid results are packed at tail in ascending FU order.
  always_comb begin
    enq_n  = '0;
    wr_off = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      wr_off[i] = PTR_W'(enq_n);
      if (fu_valid[i]) enq_n = enq_n + 3'd1;
    end
    enq_take = ready ? enq_n : 3'd0;
  end

  always_comb begin
    complete_valid      = '0;
    complete_entry      = '0;
    precise_state_valid = '0;
    target_pc           = '0;
    for (int k = 0; k < 3; k++) begin
      rd_ptr[k] = head + PTR_W'(k);
      if (live && (2'(k) < deq_n)) begin
        complete_valid[k]      = 1'b1;
        complete_entry[k]      = mem_idx[rd_ptr[k]];
        precise_state_valid[k] = mem_mis[rd_ptr[k]];
        target_pc[k]           = mem_mis[rd_ptr[k]] ? mem_pc[rd_ptr[k]] : '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || BPRecoverEN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_take);
      count <= count + CNT_W'(enq_take) - CNT_W'(deq_n);
    end
  end

  // Storage needs no reset; pointers alone define what is live.
  always_ff @(posedge clock) begin
    if (reset && !BPRecoverEN && ready) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i]) begin
          mem_idx[tail + wr_off[i]] <= fu_rob_idx[i];
          mem_mis[tail + wr_off[i]] <= fu_mispredict[i];
          mem_pc[tail + wr_off[i]]  <= fu_target_pc[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_complete_buffer.sv
// tb/tb_complete_buffer.sv - self-checking bench for complete_buffer
// Queue-based reference model; directed scenarios followed by randomized traffic.
module tb_complete_buffer;

  logic             clock;
  logic             reset;
  logic [3:0]       fu_valid;
  logic [3:0][4:0]  fu_rob_idx;
  logic [3:0]       fu_mispredict;
  logic [3:0][31:0] fu_target_pc;
  logic [3:0]       fu_ready;
  logic             BPRecoverEN;
  logic [2:0]       complete_valid;
  logic [2:0][4:0]  complete_entry;
  logic [2:0]       precise_state_valid;
  logic [2:0][31:0] target_pc;

  int checks = 0;
  int errors = 0;

  complete_buffer #(.ROB_IDX_W(5), .XLEN(32), .NUM_FU(4), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx),
    .fu_mispredict(fu_mispredict), .fu_target_pc(fu_target_pc), .fu_ready(fu_ready),
    .BPRecoverEN(BPRecoverEN), .complete_valid(complete_valid),
    .complete_entry(complete_entry), .precise_state_valid(precise_state_valid),
    .target_pc(target_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [4:0]  q_idx [$];
  logic        q_mis [$];
  logic [31:0] q_pc  [$];

  function automatic int m_deq();
    return (q_idx.size() > 3) ? 3 : q_idx.size();
  endfunction

  function automatic logic [3:0] m_ready();
    return ((8 - q_idx.size() + m_deq()) >= 4) ? 4'hf : 4'h0;
  endfunction

  function automatic int m_live();
    if (!reset || BPRecoverEN) return 0;
    return m_deq();
  endfunction

  function automatic logic [2:0] m_cv();
    logic [2:0] v = '0;
    for (int k = 0; k < m_live(); k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] m_entry(int k);
    return (k < m_live()) ? q_idx[k] : 5'd0;
  endfunction

  function automatic logic m_psv(int k);
    return (k < m_live()) ? q_mis[k] : 1'b0;
  endfunction

  function automatic logic [31:0] m_pc(int k);
    return m_psv(k) ? q_pc[k] : 32'd0;
  endfunction

  task automatic model_edge();
    logic [3:0] rdy;
    int n;
    if (!reset || BPRecoverEN) begin
      q_idx.delete(); q_mis.delete(); q_pc.delete();
    end else begin
      rdy = m_ready();
      n = m_deq();
      repeat (n) begin
        void'(q_idx.pop_front()); void'(q_mis.pop_front()); void'(q_pc.pop_front());
      end
      if (rdy != 4'h0)
        for (int i = 0; i < 4; i++)
          if (fu_valid[i]) begin
            q_idx.push_back(fu_rob_idx[i]);
            q_mis.push_back(fu_mispredict[i]);
            q_pc.push_back(fu_target_pc[i]);
          end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_rob_idx = '0; fu_mispredict = '0; fu_target_pc = '0;
  endtask

  task automatic rand_fu();
    for (int i = 0; i < 4; i++) begin
      fu_rob_idx[i]    = 5'($urandom);
      fu_mispredict[i] = 1'($urandom_range(0, 1));
      fu_target_pc[i]  = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; BPRecoverEN = 1'b0;
    rand_fu(); fu_valid = 4'hf;
    tick(); tick();
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL reset_cv got %b want 000", complete_valid); end
    checks++; if (complete_entry !== '0) begin errors++; $display("FAIL reset_entry got %h want 0", complete_entry); end
    checks++; if (precise_state_valid !== 3'b000) begin errors++; $display("FAIL reset_psv got %b want 000", precise_state_valid); end
    checks++; if (target_pc !== '0) begin errors++; $display("FAIL reset_pc got %h want 0", target_pc); end
    checks++; if (fu_ready !== 4'hf) begin errors++; $display("FAIL reset_ready got %b want 1111", fu_ready); end
    tick();
    reset = 1'b1; idle_inputs();
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL post_reset_cv got %b want 000", complete_valid); end
    tick();
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL post_reset_cv2 got %b want 000", complete_valid); end
    tick();
  endtask

  task automatic test_single();
    idle_inputs();
    fu_valid = 4'b0100; fu_rob_idx[2] = 5'd5;
    tick();
    idle_inputs();
    settle();
    checks++; if (complete_valid !== 3'b001) begin errors++; $display("FAIL single_cv got %b want 001", complete_valid); end
    checks++; if (complete_entry[0] !== 5'd5) begin errors++; $display("FAIL single_entry got %0d want 5", complete_entry[0]); end
    checks++; if (precise_state_valid !== 3'b000) begin errors++; $display("FAIL single_psv got %b want 000", precise_state_valid); end
    tick();
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL single_drain got %b want 000", complete_valid); end
    tick();
  endtask

  task automatic test_four();
    idle_inputs();
    fu_valid = 4'hf;
    for (int i = 0; i < 4; i++) fu_rob_idx[i] = 5'(i + 1);
    tick();
    idle_inputs();
    settle();
    checks++; if (complete_valid !== 3'b111) begin errors++; $display("FAIL four_cv got %b want 111", complete_valid); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (complete_entry[k] !== 5'(k + 1)) begin errors++; $display("FAIL four_lane%0d got %0d want %0d", k, complete_entry[k], k + 1); end
    end
    tick();
    settle();
    checks++; if (complete_valid !== 3'b001) begin errors++; $display("FAIL four_tail_cv got %b want 001", complete_valid); end
    checks++; if (complete_entry[0] !== 5'd4) begin errors++; $display("FAIL four_tail_entry got %0d want 4", complete_entry[0]); end
    tick();
  endtask

  task automatic test_mispredict();
    idle_inputs();
    fu_valid = 4'b0001; fu_rob_idx[0] = 5'd9; fu_mispredict[0] = 1'b1; fu_target_pc[0] = 32'h100;
    tick();
    idle_inputs();
    settle();
    checks++; if (precise_state_valid !== 3'b001) begin errors++; $display("FAIL misp_psv got %b want 001", precise_state_valid); end
    checks++; if (target_pc[0] !== 32'h100) begin errors++; $display("FAIL misp_pc0 got %h want 100", target_pc[0]); end
    checks++; if (target_pc[1] !== 32'h0 || target_pc[2] !== 32'h0) begin errors++; $display("FAIL misp_pc12 got %h %h want 0 0", target_pc[1], target_pc[2]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] sent [$];
    logic [4:0] got [$];
    int b = 0, cyc = 0, low = 0;
    while (b < 6 && cyc < 20) begin
      fu_valid = 4'hf;
      for (int i = 0; i < 4; i++) begin
        fu_rob_idx[i] = 5'(b * 4 + i); fu_mispredict[i] = 1'b0; fu_target_pc[i] = '0;
      end
      settle();
      for (int k = 0; k < 3; k++) if (complete_valid[k]) got.push_back(complete_entry[k]);
      checks++; if (fu_ready !== m_ready()) begin errors++; $display("FAIL b2b_ready got %b want %b", fu_ready, m_ready()); end
      if (m_ready() != 4'h0) begin
        for (int i = 0; i < 4; i++) sent.push_back(fu_rob_idx[i]);
        b++;
      end else low++;
      tick();
      cyc++;
    end
    checks++; if (b != 6) begin errors++; $display("FAIL b2b_timeout got %0d batches want 6", b); end
    idle_inputs();
    repeat (5) begin
      settle();
      for (int k = 0; k < 3; k++) if (complete_valid[k]) got.push_back(complete_entry[k]);
      tick();
    end
    checks++; if (low != 1) begin errors++; $display("FAIL b2b_low_cycles got %0d want 1", low); end
    checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got.size(), sent.size()); end
    for (int j = 0; j < sent.size() && j < got.size(); j++) begin
      checks++;
      if (got[j] !== sent[j]) begin errors++; $display("FAIL b2b_order[%0d] got %0d want %0d", j, got[j], sent[j]); end
    end
  endtask

  task automatic test_flush();
    for (int b = 0; b < 3; b++) begin
      fu_valid = 4'hf;
      for (int i = 0; i < 4; i++) fu_rob_idx[i] = 5'(10 + b * 4 + i);
      tick();
    end
    fu_valid = 4'hf; BPRecoverEN = 1'b1;
    for (int i = 0; i < 4; i++) fu_rob_idx[i] = 5'(28 + i);
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL flush_cv got %b want 000", complete_valid); end
    checks++; if (precise_state_valid !== 3'b000) begin errors++; $display("FAIL flush_psv got %b want 000", precise_state_valid); end
    tick();
    BPRecoverEN = 1'b0; idle_inputs();
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL post_flush_cv got %b want 000", complete_valid); end
    checks++; if (fu_ready !== 4'hf) begin errors++; $display("FAIL post_flush_ready got %b want 1111", fu_ready); end
    tick();
    settle();
    checks++; if (complete_valid !== 3'b000) begin errors++; $display("FAIL flush_dropped got %b want 000", complete_valid); end
    tick();
  endtask

  task automatic test_random();
    logic need_new = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (need_new) begin
        rand_fu();
        fu_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      end
      BPRecoverEN = ($urandom_range(0, 24) == 0);
      reset       = ($urandom_range(0, 59) != 0);
      settle();
      checks++; if (complete_valid !== m_cv()) begin errors++; $display("FAIL rnd_cv c%0d got %b want %b", c, complete_valid, m_cv()); end
      checks++; if (fu_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, fu_ready, m_ready()); end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (complete_entry[k] !== m_entry(k) || precise_state_valid[k] !== m_psv(k) || target_pc[k] !== m_pc(k)) begin
          errors++;
          $display("FAIL rnd_lane%0d c%0d got %0d/%b/%h want %0d/%b/%h", k, c, complete_entry[k],
                   precise_state_valid[k], target_pc[k], m_entry(k), m_psv(k), m_pc(k));
        end
      end
      need_new = (m_ready() != 4'h0) || !reset;
      tick();
    end
    reset = 1'b1; BPRecoverEN = 1'b0;
  endtask

  initial begin
    reset = 1'b0; BPRecoverEN = 1'b0; idle_inputs();
    test_reset();
    test_single();
    test_four();
    test_mispredict();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complete_buffer.md
# complete_buffer

Completion-side buffer between the function units and the ROB. It captures up to NUM_FU finished results per cycle into an in-order FIFO and drives up to three completions per cycle onto the ROB completion interface (complete_valid / complete_entry / precise_state_valid / target_pc). It is the transmitter for the ROB's completion receiver. It backpressures the function units when full and is flushed by branch recovery.

## Interface
Parameters:
- ROB_IDX_W, 5, width of a ROB index (matches `ROB`).
- XLEN, 32, PC width.
- NUM_FU, 4, number of function-unit result ports (1..4).
- DEPTH, 8, FIFO entries (power of two, DEPTH >= NUM_FU).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; buffer cleared on any rising edge where reset==0.
- fu_valid  in  [NUM_FU]  FU i presents a result this cycle.
- fu_rob_idx  in  [NUM_FU][ROB_IDX_W]  ROB entry of each result.
- fu_mispredict  in  [NUM_FU]  result is a mispredicted branch.
- fu_target_pc  in  [NUM_FU][XLEN]  corrected PC; meaningful only with fu_mispredict.
- fu_ready  out  [NUM_FU]  results accepted this cycle; all bits identical.
- BPRecoverEN  in  1  branch recovery; flushes the buffer.
- complete_valid  out  [3]  lane k carries a completion.
- complete_entry  out  [3][ROB_IDX_W]  ROB index per lane.
- precise_state_valid  out  [3]  lane k is a mispredicted branch.
- target_pc  out  [3][XLEN]  corrected PC per lane.

## Operation
- State: DEPTH-entry circular FIFO {rob_idx, mispredict, target_pc}, head pointer, tail pointer, count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Dequeue: deq_n = min(count, 3). Lanes 0..deq_n-1 are driven combinationally from head, head+1, head+2 (lane 0 is oldest). Unused lanes drive 0 on every field. At the edge, head advances by deq_n. The ROB always accepts, so there is no output handshake.
- Enqueue: fu_ready = ((DEPTH - count + deq_n) >= NUM_FU). When fu_ready is high, every FU with fu_valid high is written at tail in ascending FU index. Tail advances by popcount(fu_valid).
- When fu_ready is low, nothing is written. Each FU holds its valid and data stable until it sees fu_ready high.
- count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue is legal, including at count==DEPTH.
- precise_state_valid[k] = complete_valid[k] & stored mispredict. target_pc[k] = stored PC when precise_state_valid[k] is high, else 0.
- Flush: if BPRecoverEN is high in a cycle, complete_valid/precise_state_valid are forced to 0 that cycle and no enqueue occurs. At the edge, head = tail = count = 0 and all stored contents are discarded.
- Reset has priority over flush. Reset mid-operation discards all entries and in-flight inputs.

## Timing
- Reset values: count=0, head=tail=0. complete_valid=0, complete_entry=0, precise_state_valid=0, target_pc=0, fu_ready=all 1.
- Latency: a result accepted at edge t appears on a complete lane in cycle t+1 at the earliest (1 cycle), with no combinational fu→complete path.
- Throughput: 3 completions per cycle sustained. Order out equals order in.
- fu_ready depends only on registered count; there is no combinational path from fu_valid to fu_ready.
- With defaults, fu_ready is low only when count==8. Results presented when count==8 are taken the following cycle, after 3 dequeue.
- The first cycle after a flush or reset: complete_valid=0, fu_ready=1.

## Test plan
- Reset held (reset=0) 2 cycles with fu_valid=4'b1111 -> all outputs 0, fu_ready=1111, no completions in the cycle after release.
- FU2 valid, rob_idx=5, cycle t, others idle -> cycle t+1: complete_valid=001, complete_entry[0]=5, precise_state_valid=000. Cycle t+2: complete_valid=000.
- All 4 FUs valid, rob_idx 1,2,3,4, one cycle -> next cycle: lanes {1,2,3}, valid=111. Cycle after: lane0=4, valid=001.
- FU0 result, mispredict=1, pc=0x100 -> precise_state_valid=001, target_pc[0]=0x100. Lanes 1/2 target_pc=0.
- 4 FUs valid every cycle for 6 cycles -> count reaches 8, fu_ready drops for exactly one cycle, then returns to 1. No result is lost or reordered; output sequence equals input sequence.
- Buffer holding 6 entries, BPRecoverEN=1 for one cycle with fu_valid=1111 -> complete_valid=000 that cycle. Next cycle: complete_valid=000 and fu_ready=1111; the dropped inputs never appear.
